// File: rtl/beam_pkg.sv
// Shared definitions for the beam steering path: bus widths, the steering
// direction table and the scanner state encoding. The delay bank imports
// this package too, so both blocks agree on the delay-select codes.
package beam_pkg;

    localparam int PCM_W    = 19;
    localparam int SUM_W    = 22;
    localparam int NUM_DIRS = 14;
    localparam int SEL_W    = 5;
    localparam int DIR_W    = 4;

    // Broadside (no steering) code; also the reset/default winner.
    localparam logic [SEL_W-1:0] BROADSIDE_SEL = 5'd30;

    // Supported steering codes in scan order.
    localparam logic [SEL_W-1:0] DIR_TABLE [NUM_DIRS] = '{
        5'd30, 5'd31, 5'd0,  5'd1,  5'd5,  5'd6,  5'd10,
        5'd11, 5'd15, 5'd16, 5'd20, 5'd21, 5'd25, 5'd26
    };

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

    // Table lookup; indices past the table fall back to broadside.
    function automatic logic [SEL_W-1:0] dir_code(input logic [DIR_W-1:0] idx);
        if (idx < DIR_W'(NUM_DIRS)) begin
            return DIR_TABLE[idx];
        end
        return BROADSIDE_SEL;
    endfunction

endpackage

// File: rtl/abs_accumulator.sv
// Accumulates the magnitude of a two's-complement beam sample. The magnitude
// of the most negative input (-2^(SUM_W-1)) is representable as an unsigned
// SUM_W-bit value, so no saturation is needed.
module abs_accumulator
    import beam_pkg::*;
#(
    parameter int ENERGY_W = SUM_W + 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [SUM_W-1:0]    din,
    output logic [ENERGY_W-1:0] acc
);

    logic [SUM_W-1:0] mag;

    // Two's-complement magnitude, read as unsigned.
    always_comb begin
        mag = din;
        if (din[SUM_W-1]) begin
            mag = ~din + SUM_W'(1);
        end
    end

    // Running sum; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + ENERGY_W'(mag);
        end
    end

endmodule

// File: rtl/beam_scanner.sv
// Steering scan controller. Walks the delay bank through every direction in
// the table, lets the delay lines settle, measures the summed beam energy
// over a fixed window and publishes the loudest direction. Between scans the
// array stays steered at the last winner.
//
// Handshake: sample_valid is a one-cycle strobe with no back-pressure; a
// strobe is consumed only in SETTLE (count) or MEASURE (count + accumulate)
// and is dropped in every other state.
module beam_scanner
    import beam_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int SETTLE      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         continuous,
    input  logic                         sample_valid,
    input  logic [SUM_W-1:0]             beam_sum,
    output logic [SEL_W-1:0]             delay_select,
    output logic                         busy,
    output logic                         scan_done,
    output logic [SEL_W-1:0]             best_select,
    output logic [SUM_W+WINDOW_LOG2-1:0] best_energy,
    output logic [2:0]                   fsm_state
);

    localparam int ENERGY_W = SUM_W + WINDOW_LOG2;
    localparam int WINDOW   = 1 << WINDOW_LOG2;
    localparam int CNT_MAX  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW - 1);
    localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIRS - 1);

    scan_state_t         state;
    scan_state_t         state_next;

    logic [DIR_W-1:0]    dir_idx;
    logic [CNT_W-1:0]    cnt;
    logic [ENERGY_W-1:0] acc;
    logic [ENERGY_W-1:0] running_best;
    logic [SEL_W-1:0]    run_sel;
    logic                restart;

    logic                settle_end;
    logic                window_end;
    logic                last_dir;
    logic                take;
    logic                acc_clear;
    logic                acc_en;
    logic [SEL_W-1:0]    cur_sel;
    logic [SEL_W-1:0]    win_sel;
    logic [ENERGY_W-1:0] win_energy;

    assign fsm_state = state;

    abs_accumulator #(
        .ENERGY_W (ENERGY_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .enable (acc_en),
        .din    (beam_sum),
        .acc    (acc)
    );

    // Decode of counter end points and the running comparison. A tie keeps
    // the earlier direction, so only a strictly larger energy takes over.
    always_comb begin
        cur_sel    = dir_code(dir_idx);
        last_dir   = (dir_idx == LAST_DIR);
        settle_end = (state == ST_SETTLE)  && sample_valid && (cnt == SETTLE_LAST);
        window_end = (state == ST_MEASURE) && sample_valid && (cnt == WINDOW_LAST);
        acc_clear  = settle_end;
        acc_en     = (state == ST_MEASURE) && sample_valid;
        take       = (acc > running_best);
        win_sel    = take ? cur_sel : run_sel;
        win_energy = take ? acc : running_best;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_end) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (window_end) begin
                    state_next = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                state_next = last_dir ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                state_next = restart ? ST_SETTLE : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. The result is published on the edge
    // that enters DONE, using the outcome of the final comparison directly,
    // so scan_done, best_* and the busy drop all land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_idx      <= '0;
            cnt          <= '0;
            running_best <= '0;
            run_sel      <= BROADSIDE_SEL;
            restart      <= 1'b0;
            delay_select <= BROADSIDE_SEL;
            busy         <= 1'b0;
            scan_done    <= 1'b0;
            best_select  <= BROADSIDE_SEL;
            best_energy  <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dir_idx      <= '0;
                        cnt          <= '0;
                        running_best <= '0;
                        run_sel      <= BROADSIDE_SEL;
                        delay_select <= BROADSIDE_SEL;
                        busy         <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (sample_valid) begin
                        cnt <= settle_end ? '0 : cnt + CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (sample_valid) begin
                        cnt <= window_end ? '0 : cnt + CNT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (take) begin
                        running_best <= acc;
                        run_sel      <= cur_sel;
                    end
                    cnt <= '0;
                    if (last_dir) begin
                        best_select  <= win_sel;
                        best_energy  <= win_energy;
                        delay_select <= win_sel;
                        scan_done    <= 1'b1;
                        busy         <= continuous;
                        restart      <= continuous;
                    end else begin
                        dir_idx      <= dir_idx + DIR_W'(1);
                        delay_select <= dir_code(dir_idx + DIR_W'(1));
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        dir_idx      <= '0;
                        cnt          <= '0;
                        running_best <= '0;
                        run_sel      <= BROADSIDE_SEL;
                        delay_select <= BROADSIDE_SEL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beam_scanner.sv
// Bench for beam_scanner with a 4-sample window and 16-sample settle, one
// sample strobe every 4 clocks. Scan results are scored from a queue of
// expected {best_select, best_energy} values.
module tb_beam_scanner;
    import beam_pkg::*;

    localparam int WL2          = 2;
    localparam int ST           = 16;
    localparam int EW           = SUM_W + WL2;
    localparam int SCAN_STROBES = NUM_DIRS * (ST + (1 << WL2));
    localparam int SCAN_PERIOD  = 4 * SCAN_STROBES;
    localparam int START_TO_DONE = SCAN_PERIOD - 1;
    localparam int DONE_BUDGET  = 3000;

    logic             clk;
    logic             rst;
    logic             start;
    logic             continuous;
    logic             sample_valid;
    logic [SUM_W-1:0] beam_sum;
    logic [4:0]       delay_select;
    logic             busy;
    logic             scan_done;
    logic [4:0]       best_select;
    logic [EW-1:0]    best_energy;
    logic [2:0]       fsm_state;

    beam_scanner #(
        .WINDOW_LOG2 (WL2),
        .SETTLE      (ST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .sample_valid (sample_valid),
        .beam_sum     (beam_sum),
        .delay_select (delay_select),
        .busy         (busy),
        .scan_done    (scan_done),
        .best_select  (best_select),
        .best_energy  (best_energy),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- scenario-driven stimulus ----------------
    logic [4:0]       loud_sel  = 5'd2;
    logic [SUM_W-1:0] loud_val  = '0;
    logic [SUM_W-1:0] quiet_val = '0;
    logic             quiet_alt = 1'b0;
    logic             alt_sign  = 1'b0;
    int               sv_phase  = 0;

    always @(negedge clk) begin
        sv_phase     = (sv_phase + 1) % 4;
        sample_valid = (sv_phase == 0);
        if (sample_valid) alt_sign = ~alt_sign;
        if (delay_select == loud_sel) beam_sum = loud_val;
        else if (quiet_alt && alt_sign) beam_sum = -quiet_val;
        else beam_sum = quiet_val;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [EW+4:0] exp_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int prev_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (scan_done === 1'b1) begin
            logic [EW+4:0] e;
            done_cnt++;
            prev_done_cyc = done_cyc;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_scan_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("best_select", 32'(best_select), 32'(e[EW+4:EW]));
                check("best_energy", 32'(best_energy), 32'(e[EW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    int start_cyc = 0;

    // Raise start one cycle before a strobe so scan length is deterministic.
    task automatic pulse_start(input logic check_entry);
        do begin
            @(negedge clk); #1;
        end while (sv_phase != 3);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        if (check_entry) begin
            check("start_busy", 32'(busy), 32'd1);
            check("start_delay_select", 32'(delay_select), 32'd30);
        end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < DONE_BUDGET) begin
            @(negedge clk); #1;
            t++;
        end
        check("scan_done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic set_scenario(input logic [4:0] ls, input logic [SUM_W-1:0] lv,
                                input logic [SUM_W-1:0] qv, input logic qa);
        loud_sel  = ls;
        loud_val  = lv;
        quiet_val = qv;
        quiet_alt = qa;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]       loud_sel;
        logic [SUM_W-1:0] loud_val;
        logic [SUM_W-1:0] quiet_val;
        logic             quiet_alt;
        logic [4:0]       exp_sel;
        logic [EW-1:0]    exp_energy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;
        int t;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        sample_valid = 1'b0;
        beam_sum = '0;

        // code 2 is not in the table, so "loud_sel = 2" means no loud direction
        vecs[0] = '{5'd11, 22'd1000,    22'd10,      1'b1, 5'd11, 24'd4000};
        vecs[1] = '{5'd2,  22'd0,       22'h200000,  1'b0, 5'd30, 24'd8388608};
        vecs[2] = '{5'd30, 22'd500,     22'd10,      1'b1, 5'd30, 24'd2000};
        vecs[3] = '{5'd26, 22'h3FFFF9,  22'd5,       1'b1, 5'd26, 24'd28};
        vecs[4] = '{5'd2,  22'd0,       22'd0,       1'b0, 5'd30, 24'd0};
        vecs[5] = '{5'd0,  22'd10,      22'd10,      1'b1, 5'd30, 24'd40};
        vecs[6] = '{5'd6,  22'h200000,  22'd3,       1'b1, 5'd6,  24'd8388608};

        // reset, then a long idle stretch
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("reset_delay_select", 32'(delay_select), 32'd30);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_scan_done", 32'(scan_done), 32'd0);
        check("reset_best_select", 32'(best_select), 32'd30);
        check("reset_best_energy", 32'(best_energy), 32'd0);

        // table-driven single scans
        for (int i = 0; i < 7; i++) begin
            set_scenario(vecs[i].loud_sel, vecs[i].loud_val, vecs[i].quiet_val, vecs[i].quiet_alt);
            exp_q.push_back({vecs[i].exp_sel, vecs[i].exp_energy});
            base = done_cnt;
            pulse_start(1'b1);
            wait_done(base + 1);
            check("scan_length", 32'(done_cyc - start_cyc), 32'(START_TO_DONE));
            check("done_busy_low", 32'(busy), 32'd0);
            check("done_delay_select", 32'(delay_select), 32'(vecs[i].exp_sel));
            @(negedge clk); #1;
            check("scan_done_one_cycle", 32'(scan_done), 32'd0);
            repeat (10) @(negedge clk);
            #1;
            check("idle_delay_select", 32'(delay_select), 32'(vecs[i].exp_sel));
        end

        // reset in the middle of measuring direction 5 (code 6)
        set_scenario(vecs[0].loud_sel, vecs[0].loud_val, vecs[0].quiet_val, vecs[0].quiet_alt);
        exp_q.push_back({vecs[0].exp_sel, vecs[0].exp_energy});
        pulse_start(1'b1);
        t = 0;
        while (!(fsm_state == 3'd2 && delay_select == 5'd6) && t < DONE_BUDGET) begin
            @(negedge clk); #1;
            t++;
        end
        check("reach_dir5_measure", 32'(t < DONE_BUDGET), 32'd1);
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_delay_select", 32'(delay_select), 32'd30);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_scan_done", 32'(scan_done), 32'd0);
        check("abort_best_select", 32'(best_select), 32'd30);
        check("abort_best_energy", 32'(best_energy), 32'd0);
        repeat (200) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(base));
        exp_q.push_back({vecs[0].exp_sel, vecs[0].exp_energy});
        pulse_start(1'b1);
        wait_done(base + 1);
        check("post_abort_length", 32'(done_cyc - start_cyc), 32'(START_TO_DONE));

        // start pulses while busy and during DONE are ignored
        set_scenario(vecs[2].loud_sel, vecs[2].loud_val, vecs[2].quiet_val, vecs[2].quiet_alt);
        exp_q.push_back({vecs[2].exp_sel, vecs[2].exp_energy});
        base = done_cnt;
        pulse_start(1'b1);
        repeat (400) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(base + 1);
        check("busy_start_length", 32'(done_cyc - start_cyc), 32'(START_TO_DONE));
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("done_start_busy", 32'(busy), 32'd0);
        check("done_start_state", 32'(fsm_state), 32'd0);
        check("done_start_count", 32'(done_cnt), 32'(base + 1));

        // continuous back-to-back scans, then drop continuous mid-scan
        set_scenario(vecs[0].loud_sel, vecs[0].loud_val, vecs[0].quiet_val, vecs[0].quiet_alt);
        for (int k = 0; k < 4; k++) exp_q.push_back({vecs[0].exp_sel, vecs[0].exp_energy});
        base = done_cnt;
        continuous = 1'b1;
        pulse_start(1'b1);
        wait_done(base + 1);
        check("cont_busy_at_done", 32'(busy), 32'd1);
        wait_done(base + 2);
        check("cont_gap_1", 32'(done_cyc - prev_done_cyc), 32'(SCAN_PERIOD));
        wait_done(base + 3);
        check("cont_gap_2", 32'(done_cyc - prev_done_cyc), 32'(SCAN_PERIOD));
        repeat (500) @(negedge clk);
        #1 continuous = 1'b0;
        wait_done(base + 4);
        check("cont_gap_3", 32'(done_cyc - prev_done_cyc), 32'(SCAN_PERIOD));
        check("cont_final_busy", 32'(busy), 32'd0);
        repeat (1500) @(negedge clk);
        #1;
        check("cont_stop_count", 32'(done_cnt), 32'(base + 4));
        check("cont_stop_state", 32'(fsm_state), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
